io_responder: RTL and testbench

Device-side responder for the core's I/O instruction interface. It accepts `out_issued`/`out_data` byte writes into a transmit FIFO and serves `in_issued` reads from a receive FIFO, returning `in_data_valid`/`in_data`. It stalls the pipeline through `io_stall` when it cannot complete a request. It sits between the core and the byte-level UART TX/RX blocks, and also latches the core's `status` word onto board LEDs.

---
 rtl/io_pkg.sv | 13 +
 rtl/io_fifo.sv | 74 +++++++
 rtl/io_responder.sv | 95 +++++++++
 tb/tb_io_responder.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared widths and depth for the I/O responder and its FIFOs.
package io_pkg;

    localparam int unsigned IO_FIFO_DEPTH = 16;
    localparam int unsigned IO_BYTE_W     = 8;
    localparam int unsigned IO_WORD_W     = 32;

    // Zero-extend a byte to a core data word.
    function automatic logic [IO_WORD_W-1:0] io_zext_byte(input logic [IO_BYTE_W-1:0] b);
        return {{(IO_WORD_W - IO_BYTE_W){1'b0}}, b};
    endfunction

endpackage

// File: rtl/io_fifo.sv
// Synchronous show-ahead FIFO with an occupancy counter wide enough to hold DEPTH.
module io_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Flags come straight from the registered count; no same-cycle bypass.
    always_comb begin
        full    = (count_q == CntW'(DEPTH));
        empty   = (count_q == '0);
        do_push = push & ~full;
        do_pop  = pop & ~empty;
        // Empty FIFO presents zero rather than stale storage.
        dout    = empty ? '0 : mem_q[rd_ptr_q];
    end

    // Pointer and occupancy next-state; pointers wrap modulo DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers; reset empties the FIFO at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset since the count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/io_responder.sv
// Device-side responder: TX/RX byte FIFOs between the core I/O interface and the UART.
module io_responder
    import io_pkg::*;
#(
    parameter int unsigned DEPTH = IO_FIFO_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 out_issued,
    input  logic [IO_WORD_W-1:0] out_data,
    input  logic                 in_issued,
    output logic                 in_data_valid,
    output logic [IO_WORD_W-1:0] in_data,
    output logic                 io_stall,
    input  logic [IO_WORD_W-1:0] status,
    output logic [IO_BYTE_W-1:0] led,
    output logic [IO_BYTE_W-1:0] tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    input  logic [IO_BYTE_W-1:0] rx_data,
    input  logic                 rx_valid,
    output logic                 overrun
);

    logic                 tx_full, tx_empty, tx_push, tx_pop;
    logic                 rx_full, rx_empty, rx_push, rx_pop;
    logic [IO_BYTE_W-1:0] tx_head, rx_head;
    logic                 overrun_q, overrun_d;
    logic [IO_BYTE_W-1:0] led_q, led_d;
    logic                 unused_bits;

    // Only the low byte of the payload and status word is consumed.
    assign unused_bits = ^{out_data[IO_WORD_W-1:IO_BYTE_W], status[IO_WORD_W-1:IO_BYTE_W]};

    // Request handshakes: each side completes or stalls independently.
    always_comb begin
        tx_push       = out_issued & ~tx_full;
        tx_valid      = ~tx_empty;
        tx_data       = tx_head;
        tx_pop        = tx_valid & tx_ready;
        rx_push       = rx_valid & ~rx_full;
        rx_pop        = in_issued & ~rx_empty;
        in_data_valid = rx_pop;
        in_data       = rx_pop ? io_zext_byte(rx_head) : '0;
        io_stall      = (out_issued & tx_full) | (in_issued & rx_empty);
        overrun       = overrun_q;
        led           = led_q;
    end

    // Sticky overrun on a dropped RX byte; LED mirror of the status low byte.
    always_comb begin
        overrun_d = overrun_q | (rx_valid & rx_full);
        led_d     = status[IO_BYTE_W-1:0];
    end

    // Overrun flag and LED register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun_q <= 1'b0;
            led_q     <= '0;
        end else begin
            overrun_q <= overrun_d;
            led_q     <= led_d;
        end
    end

    io_fifo #(
        .WIDTH (IO_BYTE_W),
        .DEPTH (DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .din   (out_data[IO_BYTE_W-1:0]),
        .pop   (tx_pop),
        .dout  (tx_head),
        .full  (tx_full),
        .empty (tx_empty)
    );

    io_fifo #(
        .WIDTH (IO_BYTE_W),
        .DEPTH (DEPTH)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .din   (rx_data),
        .pop   (rx_pop),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty)
    );

endmodule

// File: tb/tb_io_responder.sv
// Directed bench for io_responder.
module tb_io_responder;

    logic        clk;
    logic        rst;
    logic        out_issued;
    logic [31:0] out_data;
    logic        in_issued;
    logic        in_data_valid;
    logic [31:0] in_data;
    logic        io_stall;
    logic [31:0] status;
    logic [7:0]  led;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        overrun;

    int n_cmp;
    int n_err;

    logic [7:0]  tx_seen [$];
    logic [31:0] rd_seen [$];

    io_responder #(
        .DEPTH (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .out_issued    (out_issued),
        .out_data      (out_data),
        .in_issued     (in_issued),
        .in_data_valid (in_data_valid),
        .in_data       (in_data),
        .io_stall      (io_stall),
        .status        (status),
        .led           (led),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .overrun       (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record completed TX handshakes and reads, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            if (tx_valid && tx_ready) tx_seen.push_back(tx_data);
            if (in_data_valid) rd_seen.push_back(in_data);
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        rst        = 1'b0;
        out_issued = 1'b0;
        out_data   = 32'h0;
        in_issued  = 1'b0;
        status     = 32'hDEAD_BEA5;
        tx_ready   = 1'b0;
        rx_data    = 8'h0;
        rx_valid   = 1'b0;

        // Reset state
        #1;
        check_val("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
        check_val("rst_tx_data", {24'b0, tx_data}, 32'h0);
        check_val("rst_in_valid", {31'b0, in_data_valid}, 32'h0);
        check_val("rst_in_data", in_data, 32'h0);
        check_val("rst_stall", {31'b0, io_stall}, 32'h0);
        check_val("rst_overrun", {31'b0, overrun}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_led_held", {24'b0, led}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        @(negedge clk);
        check_val("led_follow", {24'b0, led}, 32'hA5);

        // Write and drain
        tick();
        tx_seen.delete();
        tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            out_issued = 1'b1;
            out_data   = 32'hFFFF_FF41 + i;
            @(negedge clk);
            check_val("wr_stall", {31'b0, io_stall}, 32'h0);
            tick();
        end
        out_issued = 1'b0;
        repeat (3) tick();
        check_val("wr_count", tx_seen.size(), 3);
        for (int i = 0; i < 3; i++) check_val("wr_byte", {24'b0, tx_seen[i]}, 32'h41 + i);

        // TX full: 16 writes fill, 17th stalls until a pop frees a slot
        tx_ready = 1'b0;
        tx_seen.delete();
        for (int i = 0; i < 16; i++) begin
            out_issued = 1'b1;
            out_data   = i + 1;
            @(negedge clk);
            check_val("fill_stall", {31'b0, io_stall}, 32'h0);
            tick();
        end
        out_data = 32'h11;
        @(negedge clk);
        check_val("full_stall", {31'b0, io_stall}, 32'h1);
        tick();
        @(negedge clk);
        check_val("full_stall_hold", {31'b0, io_stall}, 32'h1);
        tick();
        tx_ready = 1'b1;
        @(negedge clk);
        check_val("full_pop_stall", {31'b0, io_stall}, 32'h1);
        tick();
        tx_ready = 1'b0;
        @(negedge clk);
        check_val("full_release", {31'b0, io_stall}, 32'h0);
        tick();
        out_issued = 1'b0;
        tx_ready   = 1'b1;
        repeat (20) tick();
        check_val("full_count", tx_seen.size(), 17);
        for (int i = 0; i < 17; i++) check_val("full_byte", {24'b0, tx_seen[i]}, i + 1);
        check_val("full_drained", {31'b0, tx_valid}, 32'h0);

        // Read from empty
        tx_ready  = 1'b0;
        in_issued = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("rd_empty_stall", {31'b0, io_stall}, 32'h1);
            check_val("rd_empty_valid", {31'b0, in_data_valid}, 32'h0);
            check_val("rd_empty_data", in_data, 32'h0);
            tick();
        end
        rx_valid = 1'b1;
        rx_data  = 8'h5A;
        @(negedge clk);
        check_val("rd_same_cycle_stall", {31'b0, io_stall}, 32'h1);
        tick();
        rx_valid = 1'b0;
        @(negedge clk);
        check_val("rd_go_stall", {31'b0, io_stall}, 32'h0);
        check_val("rd_go_valid", {31'b0, in_data_valid}, 32'h1);
        check_val("rd_go_data", in_data, 32'h0000_005A);
        tick();
        in_issued = 1'b0;

        // RX overflow
        for (int i = 0; i < 17; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'h80 + 8'(i);
            @(negedge clk);
            check_val("ovf_pre", {31'b0, overrun}, 32'h0);
            tick();
        end
        rx_valid = 1'b0;
        @(negedge clk);
        check_val("ovf_set", {31'b0, overrun}, 32'h1);
        tick();
        rd_seen.delete();
        in_issued = 1'b1;
        repeat (16) tick();
        @(negedge clk);
        check_val("ovf_17th_absent", {31'b0, io_stall}, 32'h1);
        check_val("ovf_sticky", {31'b0, overrun}, 32'h1);
        tick();
        in_issued = 1'b0;
        check_val("ovf_count", rd_seen.size(), 16);
        for (int i = 0; i < 16; i++) check_val("ovf_byte", rd_seen[i], 32'h80 + i);

        // Streaming with concurrent push/pop across pointer wrap
        tx_seen.delete();
        rd_seen.delete();
        for (int i = 0; i < 40; i++) begin
            out_issued = 1'b1;
            out_data   = 32'hC0 + i;
            rx_valid   = 1'b1;
            rx_data    = 8'h20 + 8'(i);
            tx_ready   = (i >= 5);
            in_issued  = (i >= 5);
            @(negedge clk);
            check_val("stream_stall", {31'b0, io_stall}, 32'h0);
            tick();
        end
        out_issued = 1'b0;
        rx_valid   = 1'b0;
        repeat (5) tick();
        @(negedge clk);
        check_val("stream_tx_empty", {31'b0, tx_valid}, 32'h0);
        check_val("stream_rx_empty", {31'b0, io_stall}, 32'h1);
        tick();
        in_issued = 1'b0;
        tx_ready  = 1'b0;
        check_val("stream_tx_count", tx_seen.size(), 40);
        check_val("stream_rd_count", rd_seen.size(), 40);
        for (int i = 0; i < 40; i++) begin
            check_val("stream_tx_byte", {24'b0, tx_seen[i]}, 32'hC0 + i);
            check_val("stream_rd_byte", rd_seen[i], 32'h20 + i);
        end

        // Reset mid-traffic
        for (int i = 0; i < 3; i++) begin
            out_issued = 1'b1;
            out_data   = 32'h60 + i;
            rx_valid   = 1'b1;
            rx_data    = 8'h70 + 8'(i);
            tick();
        end
        out_issued = 1'b0;
        rx_valid   = 1'b0;
        rst        = 1'b0;
        #1;
        check_val("mid_rst_tx_valid", {31'b0, tx_valid}, 32'h0);
        check_val("mid_rst_tx_data", {24'b0, tx_data}, 32'h0);
        check_val("mid_rst_overrun", {31'b0, overrun}, 32'h0);
        check_val("mid_rst_led", {24'b0, led}, 32'h0);
        check_val("mid_rst_stall", {31'b0, io_stall}, 32'h0);
        in_issued = 1'b1;
        #1;
        check_val("mid_rst_in_valid", {31'b0, in_data_valid}, 32'h0);
        check_val("mid_rst_in_data", in_data, 32'h0);
        in_issued = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick();
        in_issued = 1'b1;
        @(negedge clk);
        check_val("post_rst_tx_empty", {31'b0, tx_valid}, 32'h0);
        check_val("post_rst_rx_empty", {31'b0, io_stall}, 32'h1);
        check_val("post_rst_led", {24'b0, led}, 32'hA5);
        tick();
        in_issued = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
